// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the FSM state encoding (the TX FSM uses the same numbering),
// the legal oversampling ratios and the parity-type encoding.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-tap majority sampler for the UART receiver.
// Captures the line at edges P/2-1 and P/2 of a bit period and votes them
// together with the live line value at edge P/2+1.
// Ports:
//   CLK         oversampling clock
//   i_rx_in     serial line (already synchronized)
//   i_edge_cnt  position inside the current bit (0..P-1)
//   i_prescale  latched oversampling ratio P
//   o_bit       majority-voted bit value (meaningful when o_bit_vld)
//   o_bit_vld   high at edge P/2+1, when o_bit is the settled vote
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               i_rx_in,
  input  logic [PRESC_W-1:0] i_edge_cnt,
  input  logic [PRESC_W-1:0] i_prescale,
  output logic               o_bit,
  output logic               o_bit_vld
);

  localparam logic [PRESC_W-1:0] C_ONE = PRESC_W'(1);

  function automatic logic f_maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [PRESC_W-1:0] w_half;
  logic               w_hit0;
  logic               w_hit1;
  logic               r_tap0;
  logic               r_tap1;

  assign w_half = i_prescale >> 1;
  assign w_hit0 = (i_edge_cnt == (w_half - C_ONE));
  assign w_hit1 = (i_edge_cnt == w_half);

  // Tap registers: pure data, only meaningful once both sample edges passed.
  always_ff @(posedge CLK) begin
    if (w_hit0) r_tap0 <= i_rx_in;
    if (w_hit1) r_tap1 <= i_rx_in;
  end

  // Third tap is the live line, so the vote is ready at edge P/2+1.
  assign o_bit     = f_maj3(r_tap0, r_tap1, i_rx_in);
  assign o_bit_vld = (i_edge_cnt == (w_half + C_ONE));

endmodule

// File: rtl/uart_rx.sv
// UART receive engine.
// Detects a start bit on the oversampled line, majority-votes every bit,
// deserializes DATA_WIDTH bits LSB-first, checks optional parity and the
// stop bit, and reports the frame with one-cycle strobes.
// Ports:
//   CLK         oversampling clock
//   RST         asynchronous active-low reset
//   RX_IN       serial line, idle high
//   PRESCALE    oversampling ratio (8/16/32, anything else behaves as 8)
//   PAR_EN      frame carries a parity bit
//   PAR_TYP     0 = even, 1 = odd parity
//   P_DATA      last error-free word
//   DATA_VALID  one-cycle strobe, P_DATA just loaded
//   PAR_ERR     one-cycle strobe, parity mismatch
//   STP_ERR     one-cycle strobe, stop bit sampled low
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESC_W-1:0] C_ONE     = PRESC_W'(1);
  localparam logic [BIT_W-1:0]   C_BIT_ONE = BIT_W'(1);
  localparam logic [BIT_W-1:0]   C_BIT_MAX = BIT_W'(DATA_WIDTH - 1);

  // Unsupported ratios fall back to 8.
  function automatic logic [PRESC_W-1:0] f_legal_presc(input logic [PRESC_W-1:0] p);
    if (p == PRESC_W'(PRESC_16) || p == PRESC_W'(PRESC_32)) return p;
    return PRESC_W'(PRESC_8);
  endfunction

  uart_state_e           r_state;
  uart_state_e           w_next;
  logic [PRESC_W-1:0]    r_edge_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [PRESC_W-1:0]    r_presc;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_err;
  logic                  r_stop_ok;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_bit;
  logic                  w_bit_vld;
  logic                  w_last_edge;
  logic                  w_par_exp;

  uart_rx_sampler #(
    .PRESC_W(PRESC_W)
  ) u_sampler (
    .CLK       (CLK),
    .i_rx_in   (RX_IN),
    .i_edge_cnt(r_edge_cnt),
    .i_prescale(r_presc),
    .o_bit     (w_bit),
    .o_bit_vld (w_bit_vld)
  );

  assign w_last_edge = (r_edge_cnt == (r_presc - C_ONE));
  assign w_par_exp   = (^r_data) ^ r_par_typ;

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (!RX_IN) w_next = START;
      START: begin
        if (w_bit_vld && w_bit) w_next = IDLE;
        else if (w_last_edge)   w_next = DATA;
      end
      DATA:   if (w_last_edge && (r_bit_cnt == C_BIT_MAX)) w_next = r_par_en ? PARITY : STOP;
      PARITY: if (w_last_edge) w_next = STOP;
      // Return through IDLE: a low line in the next cycle restarts at once.
      STOP:   if (w_last_edge) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Counters, per-frame configuration and checker flags
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_presc    <= PRESC_W'(PRESC_8);
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_err  <= 1'b0;
      r_stop_ok  <= 1'b0;
    end else if (r_state == IDLE) begin
      if (!RX_IN) begin
        // Detection cycle counts as edge 0, so the next one is edge 1.
        r_edge_cnt <= C_ONE;
        r_bit_cnt  <= '0;
        r_presc    <= f_legal_presc(PRESCALE);
        r_par_en   <= PAR_EN;
        r_par_typ  <= PAR_TYP;
        r_par_err  <= 1'b0;
      end
    end else begin
      if ((w_next == IDLE) || w_last_edge) r_edge_cnt <= '0;
      else                                 r_edge_cnt <= r_edge_cnt + C_ONE;

      if ((r_state == DATA) && w_last_edge)
        r_bit_cnt <= (r_bit_cnt == C_BIT_MAX) ? '0 : r_bit_cnt + C_BIT_ONE;

      if ((r_state == PARITY) && w_bit_vld) r_par_err <= (w_bit != w_par_exp);
      if ((r_state == STOP) && w_bit_vld)   r_stop_ok <= w_bit;
    end
  end

  // Deserializer
  always_ff @(posedge CLK) begin
    if ((r_state == DATA) && w_bit_vld) r_data[r_bit_cnt] <= w_bit;
  end

  // Frame verdict, registered strobes
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      if ((r_state == STOP) && w_last_edge) begin
        STP_ERR <= ~r_stop_ok;
        PAR_ERR <= r_par_err;
        if (r_stop_ok && !r_par_err) begin
          DATA_VALID <= 1'b1;
          P_DATA     <= r_data;
        end
      end
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive engine for the UART link. It is the counterpart of the transmit FSM/serializer path. It oversamples RX_IN, detects a start bit, majority-votes each bit, and deserializes DATA_WIDTH bits LSB-first. It then checks an optional parity bit and the stop bit, and presents the word on P_DATA with a one-cycle DATA_VALID strobe. It sits between the pad-side synchronizer and the system register/FIFO that consumes received bytes.

## Interface
- DATA_WIDTH, 8, payload bits per frame
- PRESC_W, 6, width of PRESCALE input
- CLK  in  1  oversampling clock
- RST  in  1  reset; asynchronous, active-low
- RX_IN  in  1  serial line, idle high; already synchronized to CLK upstream
- PRESCALE  in  PRESC_W  oversampling ratio; legal 8, 16, 32; any other value is treated as 8
- PAR_EN  in  1  1 = frame carries a parity bit
- PAR_TYP  in  1  0 = even, 1 = odd
- P_DATA  out  DATA_WIDTH  last received word, registered
- DATA_VALID  out  1  one-cycle strobe, error-free frame on P_DATA
- PAR_ERR  out  1  one-cycle strobe, parity mismatch
- STP_ERR  out  1  one-cycle strobe, stop bit sampled 0

## Operation
- Reset values: all outputs 0; state IDLE; counters 0.
- PRESCALE, PAR_EN and PAR_TYP are latched at start detection and held for the whole frame. Changes mid-frame have no effect.
- edge_cnt counts 0..P-1 within a bit. bit_cnt counts bits within the frame.
- Sampler: takes RX_IN at edges P/2-1, P/2, P/2+1. The bit value is the majority of 3 and is valid at edge P/2+1.
- States:
  - IDLE: RX_IN==0 -> START. That cycle is edge 0.
  - START: at sample point, voted bit 1 -> IDLE (glitch; no strobes, P_DATA unchanged). Otherwise, at edge P-1 -> DATA.
  - DATA: shift the voted bit into bit index bit_cnt (LSB first). After DATA_WIDTH bits, at edge P-1 -> PARITY if PAR_EN, else STOP.
  - PARITY: compare the voted bit with the XOR of the data bits (inverted when PAR_TYP=1). At edge P-1 -> STOP. The mismatch is recorded.
  - STOP: at edge P-1, evaluate the frame.
    - Voted stop bit 0 -> STP_ERR.
    - Parity mismatch recorded -> PAR_ERR.
    - Both errors may assert together.
    - No error -> load P_DATA and pulse DATA_VALID.
    - Next state: IDLE, or START directly if RX_IN==0 in the cycle after edge P-1 (back-to-back frames, no idle bit required).
- On any error, P_DATA holds its previous value.
- Reset mid-frame: immediate return to IDLE. No strobe is emitted and the partial word is discarded.

## Timing
- Frame length: F = 1 + DATA_WIDTH + PAR_EN + 1 bits.
- Cycle 0 is the first cycle in which RX_IN is seen low in IDLE.
- Strobes (DATA_VALID / PAR_ERR / STP_ERR) are registered and high for exactly one cycle, in cycle F*P.
  - P=8, no parity: cycle 80.
  - P=8, parity: cycle 88.
  - P=16, parity: cycle 176.
- P_DATA updates in the same cycle DATA_VALID rises.
- A start glitch returns the block to IDLE by cycle P/2+2. A new start can be detected in the following cycle.
- Back-to-back: the second frame's cycle 0 is cycle F*P, which overlaps the first frame's strobe cycle.
- Throughput: one word per F*P cycles. There is no backpressure; the consumer must accept on DATA_VALID.

## Structure
- Shared package uart_pkg holds:
  - the state encodings (IDLE, START, DATA, PARITY, STOP; 3-bit, shared numbering with the TX FSM)
  - the legal PRESCALE constants (8, 16, 32)
  - PAR_TYP encoding constants (EVEN=0, ODD=1)
- Sub-module uart_rx_sampler contains the three-tap majority voter and the sample-point decode from edge_cnt/PRESCALE.
- The FSM, counters, deserializer and checkers live in uart_rx.

## Test plan
- P=8, PAR_EN=0, send 0xA5 -> P_DATA=0xA5, DATA_VALID high in cycle 80 only, no error strobes.
- P=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity bit 0 -> DATA_VALID in cycle 176. The same frame with parity bit 1 -> PAR_ERR in cycle 176, P_DATA keeps 0x3C from before.
- P=8, PAR_TYP=1, send 0xFF with stop bit 0 -> STP_ERR pulse in cycle 88, no DATA_VALID.
- Hold RX_IN low for 2 cycles at P=8 (glitch) -> back in IDLE, no strobe. A valid 0x12 frame sent afterwards is received correctly.
- Two back-to-back frames 0x01 then 0x80, P=32, no idle gap -> two DATA_VALID pulses 320 cycles apart with correct data. A one-cycle noise spike inside a data bit at edge P/2 is voted out.
- Assert RST in the middle of the DATA state -> all outputs 0 immediately. The next full frame decodes correctly.
